alu_md_unit: RTL and testbench

ALU_MD_UNIT -- requirements
Module: alu_md_unit

---
 rtl/alu_md_if.sv | 26 ++
 rtl/alu_md_unit.sv | 194 +++++++++++++++++++
 tb/tb_alu_md_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_md_if.sv
// rtl/alu_md_if.sv - operation request / result bundle for alu_md_unit
interface alu_md_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, funct, shamt, rs_data, rt_data,
        input  in_ready, out_valid, out_data, overflow, illegal
    );

    modport slave (
        input  in_valid, funct, shamt, rs_data, rt_data,
        output in_ready, out_valid, out_data, overflow, illegal
    );
endinterface

// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - MIPS R-type ALU with iterative HI/LO multiply/divide
// Optional divider enabled by defining ALU_MD_DIV_EN.
module alu_md_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clock,
    input logic     reset,
    alu_md_if.slave bus
);
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_next;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   hi, lo, mcand;
    logic [2*WIDTH-1:0] acc;
    logic               neg_lo;
    logic               accept, is_mul, sgn;
    logic [WIDTH-1:0]   rs, rt, sum, diff;

    assign rs       = bus.rs_data;
    assign rt       = bus.rt_data;
    assign sum      = rs + rt;
    assign diff     = rs - rt;
    assign bus.in_ready = (state == IDLE);
    assign accept   = bus.in_valid && (state == IDLE);
    assign is_mul   = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    // Odd function codes in the MULT/DIV group are the unsigned forms.
    assign sgn      = ~bus.funct[0];

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    // Shift-add step: add multiplicand into the upper half, then shift the pair right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_prod;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign mul_prod = neg_lo ? -acc : acc;

`ifdef ALU_MD_DIV_EN
    logic               is_div, neg_hi, op_div, div_zero;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_q, div_r;
    assign is_div    = (bus.funct == 6'h1A) || (bus.funct == 6'h1B);
    // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign div_trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, mcand};
    assign div_next  = div_trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                          : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign div_q     = div_zero ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign div_r     = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

    logic [WIDTH-1:0] sc_data;
    logic             sc_ov, sc_ill;
    logic [SHW-1:0]   sh;

    always_comb begin
        sc_data = '0;
        sc_ov   = 1'b0;
        sc_ill  = 1'b0;
        sh      = bus.funct[2] ? rs[SHW-1:0] : bus.shamt;
        case (bus.funct)
            F_SLL, F_SLLV: sc_data = rt << sh;
            F_SRL, F_SRLV: sc_data = rt >> sh;
            F_SRA, F_SRAV: sc_data = WIDTH'($signed(rt) >>> sh);
            F_MFHI:        sc_data = hi;
            F_MFLO:        sc_data = lo;
            F_ADD: begin
                sc_data = sum;
                sc_ov   = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            F_ADDU:        sc_data = sum;
            F_SUB: begin
                sc_data = diff;
                sc_ov   = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            F_SUBU:        sc_data = diff;
            F_AND:         sc_data = rs & rt;
            F_OR:          sc_data = rs | rt;
            F_XOR:         sc_data = rs ^ rt;
            F_NOR:         sc_data = ~(rs | rt);
            F_SLT:         sc_data = {{(WIDTH-1){1'b0}}, $signed(rs) < $signed(rt)};
            F_SLTU:        sc_data = {{(WIDTH-1){1'b0}}, rs < rt};
            default:       sc_ill  = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul) state_next = MUL;
`ifdef ALU_MD_DIV_EN
                else if (accept && is_div) state_next = DIV;
`endif
            end
            MUL, DIV: if (cnt == LAST) state_next = FIX;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi            <= '0;
            lo            <= '0;
            mcand         <= '0;
            acc           <= '0;
            cnt           <= '0;
            neg_lo        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.overflow  <= 1'b0;
            bus.illegal   <= 1'b0;
`ifdef ALU_MD_DIV_EN
            neg_hi        <= 1'b0;
            op_div        <= 1'b0;
            div_zero      <= 1'b0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.illegal   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    if (is_mul) begin
                        mcand  <= mag(rs, sgn);
                        acc    <= {{WIDTH{1'b0}}, mag(rt, sgn)};
                        neg_lo <= sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
`ifdef ALU_MD_DIV_EN
                        op_div <= 1'b0;
                    end else if (is_div) begin
                        mcand    <= mag(rt, sgn);
                        acc      <= {{WIDTH{1'b0}}, mag(rs, sgn)};
                        neg_lo   <= sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        neg_hi   <= sgn && rs[WIDTH-1];
                        div_zero <= (rt == '0);
                        op_div   <= 1'b1;
`endif
                    end else begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= sc_data;
                        bus.overflow  <= sc_ov;
                        bus.illegal   <= sc_ill;
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
`ifdef ALU_MD_DIV_EN
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
`endif
                FIX: begin
                    bus.out_valid <= 1'b1;
`ifdef ALU_MD_DIV_EN
                    if (op_div) begin
                        hi           <= div_r;
                        lo           <= div_q;
                        bus.out_data <= div_q;
                    end else
`endif
                    begin
                        hi           <= mul_prod[2*WIDTH-1:WIDTH];
                        lo           <= mul_prod[WIDTH-1:0];
                        bus.out_data <= mul_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb/tb_alu_md_unit.sv - directed self-checking bench for alu_md_unit
module tb_alu_md_unit;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_md_if #(.WIDTH(W)) bus ();
    alu_md_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [5:0] f, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1'b1;
        bus.funct    = f;
        bus.shamt    = sa;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [5:0] f, input logic [4:0] sa,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_data, input logic exp_ov, input logic exp_ill);
        issue(f, sa, rs, rt);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(1'b1));
        check({tag, ".data"},  64'(bus.out_data),  64'(exp_data));
        check({tag, ".ovf"},   64'(bus.overflow),  64'(exp_ov));
        check({tag, ".ill"},   64'(bus.illegal),   64'(exp_ill));
    endtask

    task automatic multi(input string tag, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exp_lo);
        int lat  = 0;
        int busy = 0;
        issue(f, 5'd0, rs, rt);
        while (!bus.out_valid && lat < 100) begin
            if (!bus.in_ready) busy++;
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat),  64'(33));
        check({tag, ".busy"},    64'(busy), 64'(33));
        check({tag, ".lo"},      64'(bus.out_data), 64'(exp_lo));
    endtask

    initial begin
        int seen;
        bus.in_valid = 1'b0;
        bus.funct    = '0;
        bus.shamt    = '0;
        bus.rs_data  = '0;
        bus.rt_data  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst.in_ready",  64'(bus.in_ready),  64'(1'b1));
        check("rst.out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst.out_data",  64'(bus.out_data),  64'(0));
        check("rst.ovf",       64'(bus.overflow),  64'(1'b0));
        check("rst.ill",       64'(bus.illegal),   64'(1'b0));
        single("mflo_rst", 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        single("add_ovf",  6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0);
        @(negedge clock);
        check("add_ovf.drop_valid", 64'(bus.out_valid), 64'(1'b0));
        check("add_ovf.drop_ovf",   64'(bus.overflow),  64'(1'b0));
        single("addu",     6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0);
        single("sub_ovf",  6'h22, 5'd0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        single("subu",     6'h23, 5'd0, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("srav",     6'h07, 5'd0, 32'h24, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
        single("sll",      6'h00, 5'd31, 32'h0, 32'h3, 32'h8000_0000, 1'b0, 1'b0);
        single("srl",      6'h02, 5'd4, 32'h0, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0);
        single("sra",      6'h03, 5'd31, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("slt",      6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
        single("sltu",     6'h2B, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        single("and",      6'h24, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        single("xor",      6'h26, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0);
        single("nor",      6'h27, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("illegal",  6'h3F, 5'd0, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1);

        multi("mult",      6'h18, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB);
        single("mult.hi",  6'h10, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("mult.lo",  6'h12, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b0, 1'b0);
        multi("multu",     6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        single("multu.hi", 6'h10, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);

`ifdef ALU_MD_DIV_EN
        multi("div",       6'h1A, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
        single("div.hi",   6'h10, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        multi("divu0",     6'h1B, 32'hA, 32'h0, 32'hFFFF_FFFF);
        single("divu0.hi", 6'h10, 5'd0, 32'h0, 32'h0, 32'h0000_000A, 1'b0, 1'b0);
        multi("div_mneg",  6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        single("div_mneg.hi", 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`else
        single("div_off",  6'h1A, 5'd0, 32'h8, 32'h2, 32'h0, 1'b0, 1'b1);
        single("div_off.lo", 6'h12, 5'd0, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        single("div_off.hi", 6'h10, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

        issue(6'h19, 5'd0, 32'h5, 32'h6);
        repeat (9) @(negedge clock);
        check("abort.busy", 64'(bus.in_ready), 64'(1'b0));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort.in_ready", 64'(bus.in_ready),  64'(1'b1));
        check("abort.valid",    64'(bus.out_valid), 64'(1'b0));
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.out_valid) seen++;
        end
        check("abort.no_pulse", 64'(seen), 64'(0));
        single("abort.lo", 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        single("abort.hi", 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
